ux607_pwm_icb_arb: RTL and testbench

Round-robin ICB arbiter that shares the single 32-bit ICB slave port of the PWM peripheral wrapper between N requesters, e.g. the core's peripheral bus and a DMA/sequencer engine that reprograms PWM compare registers. It sits directly in front of the PWM wrapper's `i_icb_*` port. It allows exactly one outstanding transaction and routes each response back to the requester that issued the command.

---
 rtl/ux607_pwm_icb_arb_pkg.sv | 19 +
 rtl/ux607_pwm_icb_arb_if.sv | 25 ++
 rtl/ux607_rr_pick.sv | 25 ++
 rtl/ux607_pwm_icb_arb.sv | 99 +++++++++
 tb/tb_ux607_pwm_icb_arb.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ux607_pwm_icb_arb_pkg.sv
// Shared types for the PWM ICB round-robin arbiter: FSM state encoding and
// the index-width helper used by the arbiter and its picker.
package ux607_icb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

    // Requester index width; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int N_MST_DEF = 2;
    localparam int IDX_W_DEF = idx_w(N_MST_DEF);

endpackage

// File: rtl/ux607_pwm_icb_arb_if.sv
// ICB command/response bundle; N lanes packed side by side, lane k at [k*W +: W].
interface ux607_pwm_icb_arb_if #(
    parameter int N  = 1,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [N-1:0]    cmd_valid;
    logic [N-1:0]    cmd_ready;
    logic [N*AW-1:0] cmd_addr;
    logic [N-1:0]    cmd_read;
    logic [N*DW-1:0] cmd_wdata;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [N*DW-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ux607_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module ux607_rr_pick
    import ux607_icb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);
    int j;

    always_comb begin
        any = |req;
        idx = '0;
        j   = 0;
        // Walk offsets downward so the smallest offset from ptr wins last.
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (req[j]) idx = IW'(j);
        end
    end
endmodule

// File: rtl/ux607_pwm_icb_arb.sv
// Round-robin arbiter sharing the PWM wrapper's ICB slave port between N_MST
// requesters, one outstanding transaction, response routed back to the issuer.
module ux607_pwm_icb_arb
    import ux607_icb_arb_pkg::*;
#(
    parameter  int N_MST = 2,
    parameter  int AW    = 32,
    parameter  int DW    = 32,
    localparam int IW    = idx_w(N_MST)
) (
    input  logic                  clk,
    input  logic                  reset,
    ux607_pwm_icb_arb_if.slave    m,
    ux607_pwm_icb_arb_if.master   s,
    output logic                  busy,
    output logic [IW-1:0]         grant_id
);
    arb_state_e    state, state_d;
    logic [IW-1:0] gnt_q, gnt_d, rr_q, rr_d, win, sel;
    logic          any, src_en;

    ux607_rr_pick #(.N(N_MST), .IW(IW)) u_pick (
        .req (m.cmd_valid),
        .ptr (rr_q),
        .any (any),
        .idx (win)
    );

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
        return (int'(i) == N_MST - 1) ? '0 : IW'(int'(i) + 1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt_q <= '0;
            rr_q  <= '0;
        end else begin
            state <= state_d;
            gnt_q <= gnt_d;
            rr_q  <= rr_d;
        end
    end

    // Once a grant is locked in HOLD the picker output is ignored entirely.
    assign sel    = (state == HOLD) ? gnt_q : win;
    assign src_en = (state == HOLD) || ((state == IDLE) && any);

    always_comb begin
        state_d     = state;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        s.cmd_valid = 1'b0;
        s.cmd_addr  = '0;
        s.cmd_read  = 1'b0;
        s.cmd_wdata = '0;
        s.rsp_ready = 1'b0;
        m.cmd_ready = '0;
        m.rsp_valid = '0;

        if (src_en) begin
            s.cmd_valid      = m.cmd_valid[sel];
            s.cmd_addr       = m.cmd_addr[sel*AW +: AW];
            s.cmd_read       = m.cmd_read[sel];
            s.cmd_wdata      = m.cmd_wdata[sel*DW +: DW];
            m.cmd_ready[sel] = s.cmd_ready[0];
        end

        case (state)
            IDLE: begin
                if (any) begin
                    gnt_d = win;
                    if (s.cmd_ready[0]) begin
                        state_d = RSP;
                        rr_d    = next_ptr(win);
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (m.cmd_valid[gnt_q] && s.cmd_ready[0]) begin
                    state_d = RSP;
                    rr_d    = next_ptr(gnt_q);
                end
            end
            RSP: begin
                m.rsp_valid[gnt_q] = s.rsp_valid[0];
                s.rsp_ready[0]     = m.rsp_ready[gnt_q];
                if (s.rsp_valid[0] && m.rsp_ready[gnt_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m.rsp_rdata = {N_MST{s.rsp_rdata}};
    assign busy        = (state != IDLE);
    assign grant_id    = gnt_q;
endmodule

// File: tb/tb_ux607_pwm_icb_arb.sv
// Bench for ux607_pwm_icb_arb: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_ux607_pwm_icb_arb;
    import ux607_icb_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = idx_w(N);

    logic          clk = 1'b0;
    logic          reset;
    logic          busy;
    logic [IW-1:0] grant_id;

    always #5 clk = ~clk;

    ux607_pwm_icb_arb_if #(.N(N), .AW(AW), .DW(DW)) m_bus ();
    ux607_pwm_icb_arb_if #(.N(1), .AW(AW), .DW(DW)) s_bus ();

    ux607_pwm_icb_arb #(.N_MST(N), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .m        (m_bus),
        .s        (s_bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port (-1 = nobody), whether its command
    // has been taken, who gets preference next, and the last granted index.
    int owner, ptr, last_gnt, last_acc;
    bit cmd_done;

    task automatic ref_reset();
        owner = -1; cmd_done = 0; ptr = 0; last_gnt = 0; last_acc = -1;
    endtask

    task automatic ref_cycle();
        int            src;
        logic [N-1:0]  e_rdy, e_rv;
        logic          e_sv, e_rd, e_srr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        src = -1; e_rdy = '0; e_rv = '0; e_sv = 0; e_rd = 0; e_srr = 0; e_addr = '0; e_wd = '0;
        last_acc = -1;
        chk("busy", 64'(busy), 64'(owner >= 0));
        chk("grant_id", 64'(grant_id), 64'(last_gnt));
        if (owner < 0) begin
            for (int k = 0; k < N; k++)
                if (src < 0 && m_bus.cmd_valid[(ptr + k) % N]) src = (ptr + k) % N;
        end else if (!cmd_done) begin
            src = owner;
        end
        if (src >= 0) begin
            e_sv       = m_bus.cmd_valid[src];
            e_addr     = m_bus.cmd_addr[src*AW +: AW];
            e_rd       = m_bus.cmd_read[src];
            e_wd       = m_bus.cmd_wdata[src*DW +: DW];
            e_rdy[src] = s_bus.cmd_ready[0];
        end
        if (owner >= 0 && cmd_done) begin
            e_rv[owner] = s_bus.rsp_valid[0];
            e_srr       = m_bus.rsp_ready[owner];
        end
        chk("s_cmd_valid", 64'(s_bus.cmd_valid), 64'(e_sv));
        chk("s_cmd_addr", 64'(s_bus.cmd_addr), 64'(e_addr));
        chk("s_cmd_read", 64'(s_bus.cmd_read), 64'(e_rd));
        chk("s_cmd_wdata", 64'(s_bus.cmd_wdata), 64'(e_wd));
        chk("m_cmd_ready", 64'(m_bus.cmd_ready), 64'(e_rdy));
        chk("m_rsp_valid", 64'(m_bus.rsp_valid), 64'(e_rv));
        chk("s_rsp_ready", 64'(s_bus.rsp_ready), 64'(e_srr));
        chk("m_rsp_rdata", 64'(m_bus.rsp_rdata), 64'({N{s_bus.rsp_rdata}}));
        if (src >= 0 && e_sv && s_bus.cmd_ready[0]) begin
            owner = src; cmd_done = 1; ptr = (src + 1) % N; last_gnt = src; last_acc = src;
        end else if (owner < 0 && src >= 0) begin
            owner = src; last_gnt = src;
        end else if (owner >= 0 && cmd_done && s_bus.rsp_valid[0] && m_bus.rsp_ready[owner]) begin
            owner = -1; cmd_done = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ref_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        m_bus.cmd_valid = '0; m_bus.cmd_addr = '0; m_bus.cmd_read = '0;
        m_bus.cmd_wdata = '0; m_bus.rsp_ready = '0;
        s_bus.cmd_ready = '0; s_bus.rsp_valid = '0; s_bus.rsp_rdata = '0;
    endtask

    task automatic drive_cmd(input int k, input logic [AW-1:0] a, input logic rd, input logic [DW-1:0] wd);
        m_bus.cmd_valid[k]         = 1'b1;
        m_bus.cmd_addr[k*AW +: AW] = a;
        m_bus.cmd_read[k]          = rd;
        m_bus.cmd_wdata[k*DW +: DW] = wd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        ref_reset();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_grant", 64'(grant_id), 64'(0));
        reset = 1'b0;
    endtask

    logic [1:0] sim_rdy [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [1:0] sim_rv  [5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    initial begin
        reset = 1'b1;
        set_idle();
        ref_reset();

        // Single read from m0.
        do_reset();
        drive_cmd(0, 32'h0000_0008, 1'b1, '0);
        s_bus.cmd_ready = 1'b1;
        m_bus.rsp_ready = 2'b11;
        #1;
        chk("single_addr", 64'(s_bus.cmd_addr), 64'h8);
        chk("single_rdy", 64'(m_bus.cmd_ready), 64'b01);
        tick();
        m_bus.cmd_valid = '0;
        s_bus.rsp_valid = 1'b1;
        s_bus.rsp_rdata = 32'h0000_00FF;
        #1;
        chk("single_rv", 64'(m_bus.rsp_valid), 64'b01);
        chk("single_rdata0", 64'(m_bus.rsp_rdata[DW-1:0]), 64'hFF);
        chk("single_gnt", 64'(grant_id), 64'(0));
        tick();
        s_bus.rsp_valid = 1'b0;
        tick();

        // Simultaneous requests, zero-wait slave.
        do_reset();
        drive_cmd(0, 32'h10, 1'b1, '0);
        drive_cmd(1, 32'h14, 1'b0, 32'hA5A5_0001);
        s_bus.cmd_ready = 1'b1;
        s_bus.rsp_valid = 1'b1;
        m_bus.rsp_ready = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("sim_cmd_ready", 64'(m_bus.cmd_ready), 64'(sim_rdy[c]));
            chk("sim_rsp_valid", 64'(m_bus.rsp_valid), 64'(sim_rv[c]));
            tick();
            if (c == 0) chk("sim_rr_after_m0", 64'(dut.rr_q), 64'(1));
            if (c == 2) chk("sim_rr_after_m1", 64'(dut.rr_q), 64'(0));
        end
        set_idle();
        tick();

        // Slave stall while m1 holds the grant and m0 contends.
        do_reset();
        drive_cmd(1, 32'h40, 1'b0, 32'h1234_5678);
        m_bus.rsp_ready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) drive_cmd(0, 32'h44, 1'b1, '0);
            #1;
            chk("stall_wdata", 64'(s_bus.cmd_wdata), 64'h1234_5678);
            chk("stall_valid", 64'(s_bus.cmd_valid), 64'(1));
            chk("stall_rdy", 64'(m_bus.cmd_ready), 64'b00);
            tick();
            chk("stall_gnt", 64'(grant_id), 64'(1));
            chk("stall_busy", 64'(busy), 64'(1));
        end
        s_bus.cmd_ready = 1'b1;
        #1;
        chk("stall_accept", 64'(m_bus.cmd_ready), 64'b10);
        chk("stall_wdata_acc", 64'(s_bus.cmd_wdata), 64'h1234_5678);
        tick();
        m_bus.cmd_valid[1] = 1'b0;
        s_bus.rsp_valid = 1'b1;
        tick();
        #1;
        chk("stall_next_m0", 64'(m_bus.cmd_ready), 64'b01);
        tick();
        m_bus.cmd_valid = '0;
        tick();
        set_idle();
        tick();

        // Response backpressure from m0 delays the next m1 command.
        do_reset();
        drive_cmd(0, 32'h20, 1'b1, '0);
        s_bus.cmd_ready = 1'b1;
        tick();
        m_bus.cmd_valid[0] = 1'b0;
        drive_cmd(1, 32'h24, 1'b0, 32'hCAFE_0002);
        s_bus.rsp_valid = 1'b1;
        s_bus.rsp_rdata = 32'h0BAD_F00D;
        m_bus.rsp_ready = 2'b00;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bp_s_rsp_ready", 64'(s_bus.rsp_ready), 64'(0));
            chk("bp_cmd_ready", 64'(m_bus.cmd_ready), 64'b00);
            chk("bp_rsp_valid", 64'(m_bus.rsp_valid), 64'b01);
            tick();
        end
        m_bus.rsp_ready = 2'b01;
        #1;
        chk("bp_release", 64'(s_bus.rsp_ready), 64'(1));
        chk("bp_no_cmd", 64'(m_bus.cmd_ready), 64'b00);
        tick();
        #1;
        chk("bp_m1_accept", 64'(m_bus.cmd_ready), 64'b10);
        tick();
        m_bus.cmd_valid = '0;
        m_bus.rsp_ready = 2'b11;
        tick();
        set_idle();
        tick();

        // Stray slave response in IDLE.
        do_reset();
        s_bus.rsp_valid = 1'b1;
        s_bus.rsp_rdata = 32'hDEAD_BEEF;
        m_bus.rsp_ready = 2'b11;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("stray_rv", 64'(m_bus.rsp_valid), 64'b00);
            chk("stray_ready", 64'(s_bus.rsp_ready), 64'(0));
            tick();
        end

        // Reset while m1's response is in flight.
        do_reset();
        drive_cmd(1, 32'h30, 1'b1, '0);
        s_bus.cmd_ready = 1'b1;
        tick();
        m_bus.cmd_valid = '0;
        chk("mid_pre_gnt", 64'(grant_id), 64'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_gnt", 64'(grant_id), 64'(0));
        ref_reset();
        set_idle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_cmd(1, 32'h34, 1'b0, 32'h0000_1111);
        s_bus.cmd_ready = 1'b1;
        #1;
        chk("mid_post_m1", 64'(m_bus.cmd_ready), 64'b10);
        chk("mid_post_addr", 64'(s_bus.cmd_addr), 64'h34);
        tick();
        m_bus.cmd_valid = '0;
        s_bus.rsp_valid = 1'b1;
        m_bus.rsp_ready = 2'b11;
        tick();
        set_idle();
        tick();

        // Randomized traffic; requesters hold valid until their command is taken.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!m_bus.cmd_valid[k] || last_acc == k) begin
                    if ($urandom_range(0, 2) == 0)
                        drive_cmd(k, $urandom, 1'($urandom_range(0, 1)), $urandom);
                    else
                        m_bus.cmd_valid[k] = 1'b0;
                end
                m_bus.rsp_ready[k] = ($urandom_range(0, 3) != 0);
            end
            s_bus.cmd_ready = 1'($urandom_range(0, 1));
            s_bus.rsp_valid = 1'($urandom_range(0, 1));
            s_bus.rsp_rdata = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                #1;
                chk("rand_rst_busy", 64'(busy), 64'(0));
                chk("rand_rst_gnt", 64'(grant_id), 64'(0));
                ref_reset();
                set_idle();
                @(posedge clk);
                #1;
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
